// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ write-domain producers.
// Optional multi-beat grants are compiled in with `define FIFO_ARB_BURST_EN.
module fifo_push_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                    wrclk,
    input  logic                    arst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_push,
    output logic [DW-1:0]           fifo_data,
    output logic                    grant_vld,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int unsigned IW = $clog2(NREQ);

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned QUOTA = BURST;
`else
    // Single-beat grants: quota is 1 for any legal BURST.
    localparam int unsigned QUOTA = (BURST > 1) ? 1 : BURST;
`endif

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   grant_n;
    logic [IW-1:0]   last_id, last_n;
    logic [3:0]      beats, beats_n;
    logic [DW-1:0]   lanes [NREQ];
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            quota_done;
    logic            release_grant;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            lanes[i] = req_data[i*DW +: DW];
        end
    end

    // While granted last_id equals grant_id, so one scan from last_id+1 serves
    // both idle arbitration and re-arbitration on release; the holder comes last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_id) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign grant_vld  = (state == GRANTED);
    assign fifo_push  = grant_vld && req_valid[grant_id] && !fifo_full;
    assign fifo_data  = grant_vld ? lanes[grant_id] : '0;
    assign quota_done = (({1'b0, beats} + 5'd1) == 5'(QUOTA));

    always_comb begin
        req_ready = '0;
        if (grant_vld && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = grant_id;
        last_n        = last_id;
        beats_n       = beats;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANTED;
                    grant_n = pick;
                    last_n  = pick;
                    beats_n = '0;
                end
            end
            GRANTED: begin
                if (!req_valid[grant_id]) begin
                    release_grant = 1'b1;
                end else if (fifo_push) begin
                    if (quota_done) begin
                        release_grant = 1'b1;
                    end else begin
                        beats_n = beats + 4'd1;
                    end
                end
                if (release_grant) begin
                    beats_n = '0;
                    if (found) begin
                        grant_n = pick;
                        last_n  = pick;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge wrclk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= IW'(NREQ - 1);
            beats    <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            last_id  <= last_n;
            beats    <= beats_n;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: vector table plus hand-written multi-cycle
// sequences (valid drop, back-pressure, async reset). Handles FIFO_ARB_BURST_EN builds.
module tb_fifo_push_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned BURST = 4;

    logic        wrclk = 1'b0;
    logic        arst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_push;
    logic [7:0]  fifo_data;
    logic        grant_vld;
    logic [1:0]  grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wrclk = ~wrclk;

    fifo_push_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .wrclk     (wrclk),
        .arst_n    (arst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic        gv;
        logic [1:0]  gid;
        logic [3:0]  ready;
        logic        push;
        logic [7:0]  dat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input int idx, input vec_t v);
        chk($sformatf("v%0d_grant_vld", idx), 32'(grant_vld), 32'(v.gv));
        chk($sformatf("v%0d_grant_id", idx),  32'(grant_id),  32'(v.gid));
        chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'(v.ready));
        chk($sformatf("v%0d_fifo_push", idx), 32'(fifo_push), 32'(v.push));
        chk($sformatf("v%0d_fifo_data", idx), 32'(fifo_data), 32'(v.dat));
    endtask

    localparam logic [31:0] ALL = 32'hA3A2_A1A0;

    initial begin
        int sent;
        int got;

        // Inputs applied on the falling edge; expected outputs reflect grant state after prior rising edges.
        vecs.push_back('{4'b0000, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});
        vecs.push_back('{4'b0100, 32'h0011_0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});
        vecs.push_back('{4'b0100, 32'h0011_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h11});
        vecs.push_back('{4'b0100, 32'h0022_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h22});
        vecs.push_back('{4'b0100, 32'h0033_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h33});
        vecs.push_back('{4'b0000, 32'h0033_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 8'h33});
        vecs.push_back('{4'b0000, 32'h0,         1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});
        vecs.push_back('{4'b1111, ALL,           1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});
`ifdef FIFO_ARB_BURST_EN
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3});
        vecs.push_back('{4'b1111, ALL, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 8'hA0});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0});
`else
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2});
        vecs.push_back('{4'b1111, ALL, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 8'hA3});
        vecs.push_back('{4'b1111, ALL, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3});
`endif
        vecs.push_back('{4'b0000, ALL,   1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 8'hA0});
        vecs.push_back('{4'b0000, 32'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});

        arst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (3) @(negedge wrclk);
        arst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge wrclk);
            #1;
            chk("idle_grant_vld", 32'(grant_vld), 32'd0);
            chk("idle_fifo_push", 32'(fifo_push), 32'd0);
            chk("idle_req_ready", 32'(req_ready), 32'd0);
        end

        foreach (vecs[i]) begin
            @(negedge wrclk);
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            fifo_full = vecs[i].full;
            #1;
            chk_vec(i, vecs[i]);
        end

        // Requester 1 drops valid after two beats while requester 3 waits.
        req_data = 32'h6300_6100;
        @(negedge wrclk);
        req_valid = 4'b0010;
        #1;
        chk("vd_idle", 32'(grant_vld), 32'd0);
        for (int b = 0; b < 2; b++) begin
            @(negedge wrclk);
            #1;
            chk("vd_beat_gid", 32'(grant_id), 32'd1);
            chk("vd_beat_push", 32'(fifo_push), 32'd1);
        end
        @(negedge wrclk);
        req_valid = 4'b1000;
        #1;
        chk("vd_drop_gid", 32'(grant_id), 32'd1);
        chk("vd_drop_push", 32'(fifo_push), 32'd0);
        @(negedge wrclk);
        #1;
        chk("vd_handover_vld", 32'(grant_vld), 32'd1);
        chk("vd_handover_gid", 32'(grant_id), 32'd3);
        chk("vd_handover_push", 32'(fifo_push), 32'd1);
        chk("vd_handover_data", 32'(fifo_data), 32'h63);
        @(negedge wrclk);
        req_valid = '0;

        // Back-pressure: requester 2 streams six beats, FIFO full for five cycles in the middle.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge wrclk);
            req_valid = (sent < 6) ? 4'b0100 : 4'b0000;
            req_data  = {8'h00, 8'(8'h50 + sent), 16'h0000};
            fifo_full = (c >= 3 && c < 8);
            #1;
            if (fifo_full) begin
                chk("bp_push_while_full", 32'(fifo_push), 32'd0);
                chk("bp_ready_while_full", 32'(req_ready), 32'd0);
            end
            if (fifo_push) begin
                chk("bp_data_order", 32'(fifo_data), 32'(8'h50 + got));
                got++;
            end
            if (req_ready[2] && req_valid[2]) sent++;
        end
        chk("bp_beat_count", 32'(got), 32'd6);
        fifo_full = 1'b0;
        req_valid = '0;

        // Asynchronous reset between edges while granted.
        @(negedge wrclk);
        req_valid = 4'b1111;
        req_data  = ALL;
        @(negedge wrclk);
        #1;
        chk("ar_granted_before", 32'(grant_vld), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("ar_grant_vld_drop", 32'(grant_vld), 32'd0);
        chk("ar_push_drop", 32'(fifo_push), 32'd0);
        chk("ar_ready_drop", 32'(req_ready), 32'd0);
        @(negedge wrclk);
        arst_n = 1'b1;
        #1;
        chk("ar_still_idle", 32'(grant_vld), 32'd0);
        @(negedge wrclk);
        #1;
        chk("ar_prio_vld", 32'(grant_vld), 32'd1);
        chk("ar_prio_gid", 32'(grant_id), 32'd0);
        chk("ar_prio_push", 32'(fifo_push), 32'd1);
        chk("ar_prio_data", 32'(fifo_data), 32'hA0);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter sharing the single write port of the asynchronous FIFO among `NREQ` producers in the write-clock domain. Grants one requester at a time, forwards its data straight onto the FIFO `push`/`data_in` pins, and honours `full` back-pressure through per-requester valid/ready handshakes. Sits between the producer blocks and the FIFO wrapper's write side; the read side is untouched.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 8, data width; must equal the width of `fifo_pkg::data_t`
- `BURST`, 4, maximum accepted beats per grant when burst mode is compiled in (1..15)

- `wrclk`  in  1  write-domain clock; all state on rising edge
- `arst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  requester i has a beat on `req_data[i]`
- `req_data`  in  NREQ*DW  packed data, requester i at bits [i*DW +: DW]
- `req_ready`  out  NREQ  beat of requester i accepted this cycle when high with `req_valid[i]`
- `fifo_full`  in  1  FIFO full flag
- `fifo_push`  out  1  FIFO push strobe
- `fifo_data`  out  DW  FIFO write data
- `grant_vld`  out  1  a requester currently holds the grant
- `grant_id`  out  $clog2(NREQ)  index of granted requester; 0 when `grant_vld`=0

## Operation
- State: `grant_vld`, `grant_id`, round-robin pointer `last_id`, beat counter `beats` (4 bits).
- Reset values: `grant_vld`=0, `grant_id`=0, `last_id`=NREQ-1 (requester 0 highest priority first), `beats`=0. With `grant_vld`=0, all outputs are 0: `req_ready`=0, `fifo_push`=0, `fifo_data`=0.
- Combinational outputs from the registered grant:
  - `req_ready[grant_id]` = `grant_vld` & !`fifo_full`; all other ready bits are 0.
  - `fifo_push` = `grant_vld` & `req_valid[grant_id]` & !`fifo_full`.
  - `fifo_data` = `req_data[grant_id]` when `grant_vld`, else 0.
- A beat transfers when `fifo_push`=1.
- IDLE (`grant_vld`=0): if any `req_valid`, the next edge grants the first valid requester scanning `last_id`+1, `last_id`+2, … modulo NREQ. Set `grant_id`, `last_id`=`grant_id`, `beats`=0.
- GRANTED: release occurs on any of these:
  - granted `req_valid` is low;
  - transfer completes the grant's beat quota (see Configuration).
- `fifo_full` alone never releases; the grant holds and stalls.
- On release, the same edge re-arbitrates among the current `req_valid` using the round-robin scan from the releasing `grant_id`+1. The releasing requester is eligible only if no other is valid. If none valid, go to IDLE.
- No bubble between grants: a back-to-back handover sustains one beat per cycle.
- `beats` increments per transfer and clears on every new grant.
- Reset mid-operation clears the grant asynchronously; `fifo_push` drops immediately. A beat in progress is not pushed.

## Timing
- Arbitration latency: 1 cycle from `req_valid` rising (IDLE) to `req_ready`/`fifo_push`.
- Data path: 0 cycles; `fifo_data`/`fifo_push` are combinational from `req_data`/`req_valid` under the registered grant.
- `fifo_full` → `req_ready`/`fifo_push` low in the same cycle. The FIFO is never pushed while full.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready`. Dropping `req_valid` while granted forfeits the grant at the next edge.
- Peak throughput: 1 beat/cycle. Fairness: each continuously valid requester is served within NREQ grants.

## Configuration
- `FIFO_ARB_BURST_EN` defined: a grant persists for up to `BURST` transfers. Release occurs on the transfer that makes `beats`+1 == `BURST`, or earlier if `req_valid` drops. Full-stall cycles do not count toward the quota.
- Undefined: quota is 1. The grant is released after every transfer, so requesters interleave beat-by-beat. `BURST` and `beats` are unused; synthesis removes the counter.

## Test plan
- Reset then idle: `arst_n` low 3 cycles, then all `req_valid`=0 → `grant_vld`=0, `fifo_push`=0, `req_ready`=0 for 10 cycles.
- Single requester: req 2 valid with data 0x11,0x22,0x33 → first push 1 cycle after valid; FIFO receives 0x11,0x22,0x33 in order. Without burst, back-to-back beats from one requester still push every cycle.
- All 4 valid continuously, no burst → `grant_id` sequence 0,1,2,3,0,…, one push per cycle. With `FIFO_ARB_BURST_EN`, `BURST`=4 → 4 beats per `grant_id` in the same rotation.
- Back-pressure: `fifo_full`=1 for 5 cycles mid-burst → `fifo_push`=0 and `req_ready`=0 during those cycles. Grant is held, no data lost or duplicated, and the burst resumes with the remaining quota.
- Valid drop: granted requester 1 deasserts `req_valid` after 2 beats while requester 3 is valid → `grant_id`=3 on the next edge, with no idle cycle.
- Async reset mid-burst: `arst_n` low between edges → `fifo_push` and `grant_vld` drop immediately. After release, requester 0 has priority.
